plic_axil_ctrl: RTL and testbench
=================================

PLIC_AXIL_CTRL -- requirements
Module: plic_axil_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, bus/regfile address width.
REQ-002 SHALL have parameter DATA_BITS, default 32, data width; strobe width DATA_BITS/8.
REQ-003 SHALL have parameter BASE, default 32'h1000_0000, PLIC base address.
REQ-004 SHALL have parameter TARGETS, default 1, number of interrupt targets.
REQ-005 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-006 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have ports awvalid in 1 / awready out 1 / awaddr in ADDR_BITS: AXI4-Lite write address.
REQ-008 SHALL have ports wvalid in 1 / wready out 1 / wdata in DATA_BITS / wstrb in DATA_BITS/8: write data.
REQ-009 SHALL have ports bvalid out 1 / bready in 1 / bresp out 2: write response.
REQ-010 SHALL have ports arvalid in 1 / arready out 1 / araddr in ADDR_BITS: read address.
REQ-011 SHALL have ports rvalid out 1 / rready in 1 / rdata out DATA_BITS / rresp out 2: read response.
REQ-012 SHALL have port rf_addr, output, ADDR_BITS, absolute address driven to both regfile raddr and waddr.
REQ-013 SHALL have port rf_wdata, output, DATA_BITS, regfile write data.
REQ-014 SHALL have port rf_wen, output, DATA_BITS/8, regfile byte write enables.
REQ-015 SHALL have port rf_rdata, input, DATA_BITS, regfile combinational read data.
REQ-016 SHALL have ports rf_r_overflow / rf_w_overflow, input, 1 each, regfile address-out-of-map flags.
REQ-017 SHALL have port claim, output, TARGETS, one-cycle claim pulse per target.
REQ-018 SHALL have port complete, output, TARGETS, one-cycle complete pulse per target.

Function
REQ-019 SHALL implement FSM states IDLE, ACC_W, ACC_R, BRESP, RRESP; exactly one regfile access in flight.
REQ-020 IDLE: write candidate = awvalid&&wvalid; read candidate = arvalid; AW without W (or W without AW) SHALL NOT be accepted.
REQ-021 Both candidates in IDLE: grant opposite of last granted type (round-robin flag); single candidate granted directly.
REQ-022 Grant SHALL pulse awready+wready (write) or arready (read) for one cycle, capture addr/data/strb, move to ACC_W/ACC_R next cycle.
REQ-023 ACC_W (one cycle): rf_addr=captured addr, rf_wdata=captured data, rf_wen=captured wstrb only if rf_w_overflow=0 and addr[1:0]==0, else 0; next BRESP.
REQ-024 ACC_R (one cycle): rf_addr=captured addr; register rdata=rf_rdata if rf_r_overflow=0 and aligned, else 0; next RRESP.
REQ-025 resp SHALL be 2'b00 OKAY normally, 2'b10 SLVERR on overflow or addr[1:0]!=0.
REQ-026 BRESP/RRESP: hold bvalid/rvalid and bresp/rresp/rdata stable until bready/rready high at edge, then IDLE.
REQ-027 Latency: handshake cycle N -> regfile access N+1 -> bvalid/rvalid asserted N+2; max throughput one transaction per 3 cycles.
REQ-028 claim[t] SHALL be 1 exactly during ACC_R when addr-BASE == 32'h0020_0004 + t*32'h1000, t<TARGETS, no error; else 0.
REQ-029 complete[t] SHALL be 1 exactly during ACC_W under same address rule and wstrb!=0, no error; else 0.
REQ-030 wstrb==0 write SHALL return OKAY with rf_wen=0 and no complete pulse.
REQ-031 rf_wen SHALL be 0 in every state other than ACC_W; rf_addr holds last value outside ACC states.
REQ-032 Address subtraction SHALL be modulo 2^ADDR_BITS; addresses below BASE fall to regfile overflow.

Reset
REQ-033 rstn low SHALL force IDLE, all ready/valid/resp/rdata/rf_* /claim/complete to 0, round-robin flag to "last=write"; in-flight transaction dropped without response.
REQ-034 First cycle after rstn deassert SHALL be IDLE with no grant issued before the following edge.

Verification
REQ-035 Write 0x5 to BASE+0x4, wstrb 0xF -> rf_wen=0xF, rf_addr=0x1000_0004 one cycle, bresp=00 two cycles after handshake.
REQ-036 Read BASE+0x20_0004, TARGETS=1, rf_rdata=3 -> claim=1 for one cycle, rdata=3, rresp=00.
REQ-037 AW+W and AR valid simultaneously after reset -> read granted first, then write; alternation on repeat.
REQ-038 Read with rf_r_overflow=1 or araddr=BASE+0x2 -> rresp=10, rdata=0, no claim; write with rf_w_overflow=1 -> rf_wen=0, bresp=10.
REQ-039 Hold bready=0 five cycles -> bvalid/bresp stable, no new grant; rstn pulsed in ACC_R -> no claim, rvalid=0, FSM IDLE.

Source files
------------

// File: rtl/plic_axil_ctrl.sv
// AXI4-Lite slave bridging a PLIC register file.
// One regfile access in flight; claim/complete pulses per target.
module plic_axil_ctrl #(
    parameter int          ADDR_BITS = 32,
    parameter int          DATA_BITS = 32,
    parameter logic [31:0] BASE      = 32'h1000_0000,
    parameter int          TARGETS   = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [ADDR_BITS-1:0]   awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [DATA_BITS-1:0]   wdata,
    input  logic [DATA_BITS/8-1:0] wstrb,
    output logic                   bvalid,
    input  logic                   bready,
    output logic [1:0]             bresp,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [ADDR_BITS-1:0]   araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [DATA_BITS-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic [ADDR_BITS-1:0]   rf_addr,
    output logic [DATA_BITS-1:0]   rf_wdata,
    output logic [DATA_BITS/8-1:0] rf_wen,
    input  logic [DATA_BITS-1:0]   rf_rdata,
    input  logic                   rf_r_overflow,
    input  logic                   rf_w_overflow,
    output logic [TARGETS-1:0]     claim,
    output logic [TARGETS-1:0]     complete
);

    typedef enum logic [2:0] {
        IDLE,
        ACC_W,
        ACC_R,
        BRESP,
        RRESP
    } state_t;

    localparam logic [ADDR_BITS-1:0] BASE_A = ADDR_BITS'(BASE);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    state_t                 state_q, state_d;
    logic                   last_w_q, last_w_d;
    logic                   up_q, up_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [DATA_BITS/8-1:0] strb_q, strb_d;
    logic [DATA_BITS-1:0]   rdata_q, rdata_d;
    logic [1:0]             resp_q, resp_d;

    logic                 w_cand;
    logic                 r_cand;
    logic                 gnt_w;
    logic                 gnt_r;
    logic                 misalign;
    logic                 w_err;
    logic                 r_err;
    logic [ADDR_BITS-1:0] off;

    assign w_cand   = awvalid && wvalid;
    assign r_cand   = arvalid;
    assign misalign = (addr_q[1:0] != 2'b00);
    assign w_err    = rf_w_overflow || misalign;
    assign r_err    = rf_r_overflow || misalign;
    assign off      = addr_q - BASE_A;

    assign rf_addr  = addr_q;
    assign rf_wdata = data_q;
    assign rdata    = rdata_q;
    assign bvalid   = (state_q == BRESP);
    assign rvalid   = (state_q == RRESP);
    assign bresp    = (state_q == BRESP) ? resp_q : OKAY;
    assign rresp    = (state_q == RRESP) ? resp_q : OKAY;

    // State and capture registers; up_q holds off grants for the first cycle out of reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            last_w_q <= 1'b1;
            up_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            rdata_q  <= '0;
            resp_q   <= OKAY;
        end else begin
            state_q  <= state_d;
            last_w_q <= last_w_d;
            up_q     <= up_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
            rdata_q  <= rdata_d;
            resp_q   <= resp_d;
        end
    end

    // Round-robin grant: with both candidates, serve the type not served last
    always_comb begin
        gnt_w = 1'b0;
        gnt_r = 1'b0;
        if (state_q == IDLE && up_q) begin
            if (w_cand && r_cand) begin
                gnt_r = last_w_q;
                gnt_w = !last_w_q;
            end else begin
                gnt_w = w_cand;
                gnt_r = r_cand;
            end
        end
    end

    // Next-state, handshakes and regfile access
    always_comb begin
        state_d  = state_q;
        last_w_d = last_w_q;
        up_d     = 1'b1;
        addr_d   = addr_q;
        data_d   = data_q;
        strb_d   = strb_q;
        rdata_d  = rdata_q;
        resp_d   = resp_q;
        awready  = 1'b0;
        wready   = 1'b0;
        arready  = 1'b0;
        rf_wen   = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_w) begin
                    awready  = 1'b1;
                    wready   = 1'b1;
                    addr_d   = awaddr;
                    data_d   = wdata;
                    strb_d   = wstrb;
                    last_w_d = 1'b1;
                    state_d  = ACC_W;
                end else if (gnt_r) begin
                    arready  = 1'b1;
                    addr_d   = araddr;
                    last_w_d = 1'b0;
                    state_d  = ACC_R;
                end
            end
            ACC_W: begin
                rf_wen  = w_err ? '0 : strb_q;
                resp_d  = w_err ? SLVERR : OKAY;
                state_d = BRESP;
            end
            ACC_R: begin
                rdata_d = r_err ? '0 : rf_rdata;
                resp_d  = r_err ? SLVERR : OKAY;
                state_d = RRESP;
            end
            BRESP: begin
                if (bready) state_d = IDLE;
            end
            RRESP: begin
                if (rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Claim/complete decode of per-target claim/complete registers
    always_comb begin
        claim    = '0;
        complete = '0;
        for (int t = 0; t < TARGETS; t++) begin
            if (off == ADDR_BITS'(32'h0020_0004 + 32'h1000 * 32'(t))) begin
                claim[t]    = (state_q == ACC_R) && !r_err;
                complete[t] = (state_q == ACC_W) && !w_err && (strb_q != '0);
            end
        end
    end

endmodule

// File: tb/tb_plic_axil_ctrl.sv
// Testbench for plic_axil_ctrl: vector table with response scoreboard
// plus arbitration, backpressure and reset-in-flight sequences.
module tb_plic_axil_ctrl;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rstn;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] rf_addr;
    logic [31:0] rf_wdata;
    logic [3:0]  rf_wen;
    logic [31:0] rf_rdata;
    logic        rf_r_overflow, rf_w_overflow;
    logic [0:0]  claim, complete;

    plic_axil_ctrl #(
        .ADDR_BITS(32),
        .DATA_BITS(32),
        .BASE(BASE),
        .TARGETS(1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
        .rf_rdata(rf_rdata),
        .rf_r_overflow(rf_r_overflow), .rf_w_overflow(rf_w_overflow),
        .claim(claim), .complete(complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        bit          wovf;
        bit          rovf;
        logic [31:0] rfd;
        logic [3:0]  e_wen;
        logic        e_claim;
        logic        e_cmp;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[11];
    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cur    = -1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h expected %h",
                     nm, cur, act, exp);
        end
    endtask

    task automatic idle_inputs();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
    endtask

    task automatic check_resp();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sbq.pop_front();
        if (e.wr) begin
            chk("bvalid", 32'(bvalid), 32'd1);
            chk("rvalid_off", 32'(rvalid), 32'd0);
            chk("bresp", 32'(bresp), 32'(e.resp));
        end else begin
            chk("rvalid", 32'(rvalid), 32'd1);
            chk("bvalid_off", 32'(bvalid), 32'd0);
            chk("rresp", 32'(rresp), 32'(e.resp));
            chk("rdata", rdata, e.rdata);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit   hs;
        exp_t e;
        hs = 1'b0;
        rf_w_overflow = v.wovf;
        rf_r_overflow = v.rovf;
        rf_rdata      = v.rfd;
        if (v.wr) begin
            awaddr  = v.addr;
            wdata   = v.wd;
            wstrb   = v.strb;
            awvalid = 1'b1;
            wvalid  = 1'b1;
        end else begin
            araddr  = v.addr;
            arvalid = 1'b1;
        end
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = v.wr ? (awready && wready) : arready;
        end
        if (!hs) begin
            chk("hs_timeout", 32'd0, 32'd1);
            idle_inputs();
            return;
        end
        e.wr    = v.wr;
        e.resp  = v.e_resp;
        e.rdata = v.e_rdata;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("rf_wen", 32'(rf_wen), 32'(v.e_wen));
        chk("rf_addr", rf_addr, v.addr);
        chk("claim", 32'(claim), 32'(v.e_claim));
        chk("complete", 32'(complete), 32'(v.e_cmp));
        chk("valid_early", 32'(bvalid | rvalid), 32'd0);
        if (v.wr) chk("rf_wdata", rf_wdata, v.wd);
        @(negedge clk);
        check_resp();
        @(posedge clk);
        #1;
    endtask

    int   grants[4];
    int   ng;
    bit   hs2;
    int   exp_g[4];

    initial begin
        vecs[0]  = '{1, BASE + 32'h4, 32'h5, 4'hF, 0, 0, 32'h0,
                     4'hF, 0, 0, 2'b00, 32'h0};
        vecs[1]  = '{0, BASE + 32'h20_0004, 32'h0, 4'h0, 0, 0, 32'h3,
                     4'h0, 1, 0, 2'b00, 32'h3};
        vecs[2]  = '{0, BASE + 32'h8, 32'h0, 4'h0, 0, 1, 32'h55,
                     4'h0, 0, 0, 2'b10, 32'h0};
        vecs[3]  = '{0, BASE + 32'h2, 32'h0, 4'h0, 0, 0, 32'h77,
                     4'h0, 0, 0, 2'b10, 32'h0};
        vecs[4]  = '{1, BASE + 32'hC, 32'hAB, 4'hF, 1, 0, 32'h0,
                     4'h0, 0, 0, 2'b10, 32'h0};
        vecs[5]  = '{1, BASE + 32'h20_0004, 32'h9, 4'hF, 0, 0, 32'h0,
                     4'hF, 0, 1, 2'b00, 32'h0};
        vecs[6]  = '{1, BASE + 32'h20_0004, 32'h9, 4'h0, 0, 0, 32'h0,
                     4'h0, 0, 0, 2'b00, 32'h0};
        vecs[7]  = '{1, BASE + 32'h20_0006, 32'h9, 4'h3, 0, 0, 32'h0,
                     4'h0, 0, 0, 2'b10, 32'h0};
        vecs[8]  = '{0, BASE + 32'h20_1004, 32'h0, 4'h0, 0, 0, 32'h1234,
                     4'h0, 0, 0, 2'b00, 32'h1234};
        vecs[9]  = '{0, 32'h0FFF_FFFC, 32'h0, 4'h0, 0, 1, 32'hDEAD,
                     4'h0, 0, 0, 2'b10, 32'h0};
        vecs[10] = '{1, BASE + 32'h10, 32'hCAFE_F00D, 4'h6, 0, 0, 32'h0,
                     4'h6, 0, 0, 2'b00, 32'h0};
        exp_g = '{0, 1, 0, 1};

        rstn          = 1'b0;
        bready        = 1'b1;
        rready        = 1'b1;
        rf_rdata      = 32'h0;
        rf_r_overflow = 1'b0;
        rf_w_overflow = 1'b0;
        awaddr        = BASE + 32'h10;
        araddr        = BASE + 32'h14;
        wdata         = 32'h1111;
        wstrb         = 4'hF;
        awvalid       = 1'b1;
        wvalid        = 1'b1;
        arvalid       = 1'b1;

        // Reset values with all valids asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        cur = 100;
        chk("rst_ready", 32'({awready, wready, arready}), 32'd0);
        chk("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        chk("rst_resp", 32'({bresp, rresp}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rf_addr", rf_addr, 32'd0);
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_pulses", 32'({claim, complete}), 32'd0);

        // First cycle after release issues no grant
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        chk("first_cycle_grant", 32'({awready, arready}), 32'd0);

        // Contending read/write: read first, then alternate
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            @(negedge clk);
            chk("wready_eq", 32'(wready), 32'(awready));
            if (arready) begin
                grants[ng] = 0;
                ng++;
            end else if (awready) begin
                grants[ng] = 1;
                ng++;
            end
        end
        chk("grant_count", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) chk("grant_order", 32'(grants[i]), 32'(exp_g[i]));
        end
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: misaligned write held in BRESP
        cur     = 200;
        awaddr  = BASE + 32'h1;
        wdata   = 32'h42;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        hs2     = 1'b0;
        for (int i = 0; i < 20 && !hs2; i++) begin
            @(negedge clk);
            hs2 = awready;
        end
        chk("stall_hs", 32'(hs2), 32'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        bready   = 1'b0;
        araddr   = BASE + 32'h20_0004;
        arvalid  = 1'b1;
        rf_rdata = 32'h3;
        @(negedge clk);
        chk("stall_wen", 32'(rf_wen), 32'd0);
        chk("stall_cmp", 32'(complete), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_bvalid", 32'(bvalid), 32'd1);
            chk("stall_bresp", 32'(bresp), 32'd2);
            chk("stall_nogrant", 32'(arready), 32'd0);
        end
        @(posedge clk);
        #1;
        bready = 1'b1;
        @(negedge clk);
        chk("stall_bvalid_last", 32'(bvalid), 32'd1);
        @(negedge clk);
        chk("post_stall_grant", 32'(arready), 32'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("acc_r_claim", 32'(claim), 32'd1);

        // Reset pulse while in ACC_R
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_claim", 32'(claim), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rvalid", 32'(rvalid), 32'd0);
            chk("post_rst_claim", 32'(claim), 32'd0);
        end
        chk("post_rst_rf_addr", rf_addr, 32'd0);
        @(posedge clk);
        #1;

        // Vector table
        for (int k = 0; k < 11; k++) begin
            cur = k;
            run_vec(vecs[k]);
        end
        cur = 300;
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
